reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised integer register file with an integrated scoreboard: configurable data width, register count and number of read ports. x0 is hardwired to zero. The file tracks which destination registers have a write outstanding and offers optional writeback-to-read bypass. It sits between decode/issue and writeback in the core pipeline. Issue marks a destination busy, writeback clears it, and flush clears all pending state.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers including x0; power of two, ≥ 2
- NRD, 2, number of read ports, ≥ 1
- BYPASS, 1, 1 = same-cycle writeback data is forwarded to read ports; 0 = no forwarding
- AW, $clog2(NREGS), derived address width (localparam)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, combinational; port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  1 = register on port i has an outstanding write (combinational)
- wr_en  in  1  writeback valid
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback value
- iss_en  in  1  issue request: mark iss_addr busy
- iss_addr  in  AW  issue destination
- iss_ready  out  1  issue accepted this cycle (combinational)
- flush  in  1  clear all busy bits
- busy_cnt  out  AW  registered count of busy registers

## Operation
- Storage is NREGS-1 registers of XLEN bits (x1..x(NREGS-1)) plus a busy bit per register. x0 has neither data nor busy storage.
- Read, port i:
  - addr 0 → data 0, busy 0.
  - BYPASS=1 and wr_en and wr_addr==rd_addr≠0 → data wr_data, busy 0.
  - Otherwise → stored value and stored busy bit.
- Write: on wr_en with wr_addr≠0, the register takes wr_data at the edge and its busy bit clears. Writing a register that is not busy is legal; busy stays 0. wr_addr 0 is ignored entirely.
- iss_ready = (iss_addr==0) | ~busy[iss_addr] | (wr_en & wr_addr==iss_addr), gated low while flush=1. A busy destination therefore stalls issue (WAW).
- Issue takes effect only when iss_en & iss_ready. If iss_addr≠0, busy[iss_addr] is set at the edge. Issue to x0 is accepted and changes nothing.
- Same-register writeback and issue in one cycle: data is written and the busy bit ends set (issue wins).
- Flush: at the edge every busy bit clears and a concurrent issue is dropped (iss_ready=0). A concurrent wr_en still writes data.
- busy_cnt: after every edge it equals the popcount of the busy bits. Maximum is NREGS-1, which fits in AW bits. The count updates incrementally: +1 for an accepted issue to a non-busy reg≠0, −1 for a writeback clearing a busy bit, net 0 when both hit the same register. Flush sets it to 0.
- Reset (rst=1 at edge): all registers 0, all busy 0, busy_cnt 0. Reset overrides wr_en, iss_en and flush in the same cycle.

## Timing
- Reads: zero latency, purely combinational from rd_addr, stored state and (BYPASS=1) the wr_* inputs.
- Writes, issue and flush: visible one cycle after the edge. With BYPASS=0, the read on the write cycle returns the old value and old busy bit.
- iss_ready: combinational, same cycle as iss_en. There is no registered handshake; the requester holds iss_en/iss_addr until iss_ready=1.
- busy_cnt: registered; reflects the state after the most recent edge.
- Output values while rst is asserted: rd_data 0, rd_busy 0, iss_ready 1 (given flush=0), busy_cnt 0, all valid from the first edge with rst=1.
- Multiple read ports addressing the same register return identical values.

## Test plan
- Reset, then read all addresses on every port → rd_data=0, rd_busy=0, busy_cnt=0. Write x0=0xDEADBEEF, then read x0 → 0.
- Issue x5, next cycle read x5 → rd_busy=1, busy_cnt=1. Issue x5 again → iss_ready=0. Writeback x5=0x1234 with a concurrent issue x5 → iss_ready=1, x5 reads 0x1234, rd_busy=1, busy_cnt=1.
- BYPASS=1: x7 busy, writeback x7=0xA5A5A5A5 and read x7 in the same cycle → rd_data=0xA5A5A5A5, rd_busy=0. Repeat with BYPASS=0 → old data, rd_busy=1; next cycle new data, rd_busy=0.
- Issue x1..x31 back to back → busy_cnt=31. Flush with a concurrent issue x3 and writeback x4=0x99 → iss_ready=0; next cycle busy_cnt=0, x3 not busy, x4=0x99.
- Mid-operation reset: with x10 busy, busy_cnt=5 and wr_en to x10 asserted, assert rst for one edge → all registers 0, busy_cnt=0, the write is lost.
- NRD=3, XLEN=64, NREGS=16: random issue/writeback/flush traffic against a reference model → every port's rd_data and rd_busy match each cycle, and busy_cnt equals the popcount of the busy bits.

Source files
------------

// File: rtl/reg_file_sb.sv
// Integer register file with per-register busy scoreboard.
// x0 reads as zero and is never busy. Issue marks a destination busy,
// writeback clears it, flush clears all busy state. Optional same-cycle
// writeback-to-read forwarding.
module reg_file_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    output logic                iss_ready_o,
    input  logic                flush_i,
    output logic [AW-1:0]       busy_cnt_o
);

    // Storage exists only for x1..x(NREGS-1).
    logic [XLEN-1:0]  regs_q [1:NREGS-1];
    logic [NREGS-1:1] busy_q, busy_d;
    logic [AW-1:0]    busy_cnt_q, busy_cnt_d;

    // Busy view with a constant-zero x0 slot so any address can index it.
    logic [NREGS-1:0] busy_full;
    logic             wr_hit;
    logic             iss_fire;
    logic             same_hit;
    logic             cnt_inc;
    logic             cnt_dec;

    assign busy_full = {busy_q, 1'b0};
    assign wr_hit    = wr_en_i && (wr_addr_i != '0);

    // A busy destination stalls issue unless this cycle's writeback frees it.
    assign iss_ready_o = !flush_i &&
                         ((iss_addr_i == '0) || !busy_full[iss_addr_i] ||
                          (wr_en_i && (wr_addr_i == iss_addr_i)));
    assign iss_fire    = iss_en_i && iss_ready_o && (iss_addr_i != '0);
    assign same_hit    = iss_fire && wr_hit && (wr_addr_i == iss_addr_i);

    // Issue to a register freed in the same cycle counts +1 against the -1 of
    // the writeback, so the count stays put while the bit stays set.
    assign cnt_inc = iss_fire && (!busy_full[iss_addr_i] || same_hit);
    assign cnt_dec = wr_hit && busy_full[wr_addr_i];

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          fwd;
        assign ra  = rd_addr_i[p*AW +: AW];
        assign fwd = (BYPASS != 0) && wr_hit && (wr_addr_i == ra);
        assign rd_data_o[p*XLEN +: XLEN] = (ra == '0) ? '0 :
                                           fwd        ? wr_data_i : regs_q[ra];
        assign rd_busy_o[p] = (ra != '0) && !fwd && busy_full[ra];
    end

    // Next busy bits: writeback clears, issue sets (issue wins), flush clears all.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (wr_hit && (wr_addr_i == AW'(i))) busy_d[i] = 1'b0;
            if (iss_fire && (iss_addr_i == AW'(i))) busy_d[i] = 1'b1;
        end
        if (flush_i) busy_d = '0;
    end

    // Incremental popcount of the busy bits.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (flush_i) begin
            busy_cnt_d = '0;
        end else begin
            busy_cnt_d = busy_cnt_q + AW'(cnt_inc) - AW'(cnt_dec);
        end
    end

    // State update; synchronous reset overrides write, issue and flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 1; i < NREGS; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_hit) regs_q[wr_addr_i] <= wr_data_i;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and model-checked bench for reg_file_sb: default (bypass),
// no-bypass, and a 3-port 64-bit 16-register variant.
`timescale 1ns/1ps
module tb_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults, BYPASS=1
    logic        a_rst, a_wr_en, a_iss_en, a_iss_ready, a_flush;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [4:0]  a_wr_addr, a_iss_addr, a_busy_cnt;
    logic [31:0] a_wr_data;

    // Instance B: BYPASS=0
    logic        b_rst, b_wr_en, b_iss_en, b_iss_ready, b_flush;
    logic [9:0]  b_rd_addr;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [4:0]  b_wr_addr, b_iss_addr, b_busy_cnt;
    logic [31:0] b_wr_data;

    // Instance C: NRD=3, XLEN=64, NREGS=16
    logic         c_rst, c_wr_en, c_iss_en, c_iss_ready, c_flush;
    logic [11:0]  c_rd_addr;
    logic [191:0] c_rd_data;
    logic [2:0]   c_rd_busy;
    logic [3:0]   c_wr_addr, c_iss_addr, c_busy_cnt;
    logic [63:0]  c_wr_data;

    reg_file_sb u_a (
        .clk_i(clk), .rst_i(a_rst), .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data),
        .rd_busy_o(a_rd_busy), .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr),
        .wr_data_i(a_wr_data), .iss_en_i(a_iss_en), .iss_addr_i(a_iss_addr),
        .iss_ready_o(a_iss_ready), .flush_i(a_flush), .busy_cnt_o(a_busy_cnt)
    );

    reg_file_sb #(.BYPASS(0)) u_b (
        .clk_i(clk), .rst_i(b_rst), .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data),
        .rd_busy_o(b_rd_busy), .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr),
        .wr_data_i(b_wr_data), .iss_en_i(b_iss_en), .iss_addr_i(b_iss_addr),
        .iss_ready_o(b_iss_ready), .flush_i(b_flush), .busy_cnt_o(b_busy_cnt)
    );

    reg_file_sb #(.XLEN(64), .NREGS(16), .NRD(3)) u_c (
        .clk_i(clk), .rst_i(c_rst), .rd_addr_i(c_rd_addr), .rd_data_o(c_rd_data),
        .rd_busy_o(c_rd_busy), .wr_en_i(c_wr_en), .wr_addr_i(c_wr_addr),
        .wr_data_i(c_wr_data), .iss_en_i(c_iss_en), .iss_addr_i(c_iss_addr),
        .iss_ready_o(c_iss_ready), .flush_i(c_flush), .busy_cnt_o(c_busy_cnt)
    );

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_iss_en = 1'b1; a_iss_addr = 5'd3; a_flush = 1'b0;
        step();
        step();
        a_rd_addr = {5'd3, 5'd3};
        #1;
        checks++;
        if (a_rd_busy !== 2'b00 || a_rd_data !== 64'd0)
            begin errors++; $display("FAIL rst_hold_read: got %h/%b want 0/00", a_rd_data, a_rd_busy); end
        checks++;
        if (a_iss_ready !== 1'b1 || a_busy_cnt !== 5'd0)
            begin errors++; $display("FAIL rst_hold_ready_cnt: got %b/%0d want 1/0", a_iss_ready, a_busy_cnt); end
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0; a_iss_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a_rd_addr = {5'(i), 5'(i)};
            b_rd_addr = {5'(i), 5'(i)};
            #1;
            checks++;
            if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00 || b_rd_data !== 64'd0 || b_rd_busy !== 2'b00)
                begin errors++; $display("FAIL reset_read_x%0d: got %h/%b %h/%b want zero", i, a_rd_data, a_rd_busy, b_rd_data, b_rd_busy); end
        end
        for (int i = 0; i < 16; i++) begin
            c_rd_addr = {4'(i), 4'(i), 4'(i)};
            #1;
            checks++;
            if (c_rd_data !== 192'd0 || c_rd_busy !== 3'b000)
                begin errors++; $display("FAIL reset_read_c_x%0d: got %h/%b want zero", i, c_rd_data, c_rd_busy); end
        end
        checks++;
        if (a_busy_cnt !== 5'd0 || b_busy_cnt !== 5'd0 || c_busy_cnt !== 4'd0)
            begin errors++; $display("FAIL reset_cnt: got %0d %0d %0d want 0", a_busy_cnt, b_busy_cnt, c_busy_cnt); end
        // Writes to x0 are ignored, including by the forwarding path.
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hDEADBEEF; a_rd_addr = 10'd0;
        #1;
        checks++;
        if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00)
            begin errors++; $display("FAIL x0_write_fwd: got %h/%b want 0/00", a_rd_data, a_rd_busy); end
        step();
        a_wr_en = 1'b0;
        #1;
        checks++;
        if (a_rd_data !== 64'd0)
            begin errors++; $display("FAIL x0_write: got %h want 0", a_rd_data); end
    endtask

    task automatic test_issue_wb();
        a_iss_en = 1'b1; a_iss_addr = 5'd5;
        #1;
        checks++;
        if (a_iss_ready !== 1'b1)
            begin errors++; $display("FAIL issue_x5_ready: got %b want 1", a_iss_ready); end
        step();
        a_iss_en = 1'b0; a_rd_addr = {5'd5, 5'd5};
        #1;
        checks++;
        if (a_rd_busy !== 2'b11 || a_busy_cnt !== 5'd1)
            begin errors++; $display("FAIL issue_x5_busy: got %b/%0d want 11/1", a_rd_busy, a_busy_cnt); end
        a_iss_en = 1'b1;
        #1;
        checks++;
        if (a_iss_ready !== 1'b0)
            begin errors++; $display("FAIL waw_stall: got %b want 0", a_iss_ready); end
        step();
        checks++;
        if (a_busy_cnt !== 5'd1)
            begin errors++; $display("FAIL waw_stall_cnt: got %0d want 1", a_busy_cnt); end
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'h1234;
        #1;
        checks++;
        if (a_iss_ready !== 1'b1)
            begin errors++; $display("FAIL wb_frees_issue: got %b want 1", a_iss_ready); end
        step();
        a_wr_en = 1'b0; a_iss_en = 1'b0;
        #1;
        checks++;
        if (a_rd_data !== {32'h1234, 32'h1234} || a_rd_busy !== 2'b11 || a_busy_cnt !== 5'd1)
            begin errors++; $display("FAIL wb_issue_same: got %h/%b/%0d want 1234 busy 11 cnt 1", a_rd_data, a_rd_busy, a_busy_cnt); end
    endtask

    task automatic test_bypass();
        a_iss_en = 1'b1; a_iss_addr = 5'd7;
        b_iss_en = 1'b1; b_iss_addr = 5'd7;
        step();
        a_iss_en = 1'b0; b_iss_en = 1'b0;
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'hA5A5A5A5; a_rd_addr = {5'd5, 5'd7};
        b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 32'hA5A5A5A5; b_rd_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (a_rd_data !== {32'h1234, 32'hA5A5A5A5} || a_rd_busy !== 2'b10)
            begin errors++; $display("FAIL bypass_on: got %h/%b want 00001234a5a5a5a5/10", a_rd_data, a_rd_busy); end
        checks++;
        if (b_rd_data !== 64'd0 || b_rd_busy !== 2'b11 || b_busy_cnt !== 5'd1)
            begin errors++; $display("FAIL bypass_off: got %h/%b/%0d want 0/11/1", b_rd_data, b_rd_busy, b_busy_cnt); end
        step();
        a_wr_en = 1'b0; b_wr_en = 1'b0; a_rd_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (a_rd_data !== {2{32'hA5A5A5A5}} || a_rd_busy !== 2'b00 || a_busy_cnt !== 5'd1)
            begin errors++; $display("FAIL bypass_on_after: got %h/%b/%0d want a5a5a5a5 x2/00/1", a_rd_data, a_rd_busy, a_busy_cnt); end
        checks++;
        if (b_rd_data !== {2{32'hA5A5A5A5}} || b_rd_busy !== 2'b00 || b_busy_cnt !== 5'd0)
            begin errors++; $display("FAIL bypass_off_after: got %h/%b/%0d want a5a5a5a5 x2/00/0", b_rd_data, b_rd_busy, b_busy_cnt); end
    endtask

    task automatic test_fill_flush();
        // Flush gates even an issue to x0.
        a_flush = 1'b1; a_iss_en = 1'b1; a_iss_addr = 5'd0;
        #1;
        checks++;
        if (a_iss_ready !== 1'b0)
            begin errors++; $display("FAIL flush_gates_ready: got %b want 0", a_iss_ready); end
        step();
        a_flush = 1'b0;
        #1;
        checks++;
        if (a_busy_cnt !== 5'd0)
            begin errors++; $display("FAIL flush_clear_cnt: got %0d want 0", a_busy_cnt); end
        for (int i = 1; i < 32; i++) begin
            a_iss_addr = 5'(i);
            #1;
            checks++;
            if (a_iss_ready !== 1'b1)
                begin errors++; $display("FAIL fill_ready_x%0d: got %b want 1", i, a_iss_ready); end
            step();
        end
        a_iss_en = 1'b0; a_rd_addr = {5'd31, 5'd3};
        #1;
        checks++;
        if (a_busy_cnt !== 5'd31 || a_rd_busy !== 2'b11)
            begin errors++; $display("FAIL fill_cnt: got %0d/%b want 31/11", a_busy_cnt, a_rd_busy); end
        a_flush = 1'b1; a_iss_en = 1'b1; a_iss_addr = 5'd3;
        a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h99;
        #1;
        checks++;
        if (a_iss_ready !== 1'b0)
            begin errors++; $display("FAIL flush_issue_ready: got %b want 0", a_iss_ready); end
        step();
        a_flush = 1'b0; a_iss_en = 1'b0; a_wr_en = 1'b0; a_rd_addr = {5'd4, 5'd3};
        #1;
        checks++;
        if (a_busy_cnt !== 5'd0 || a_rd_busy !== 2'b00 || a_rd_data[63:32] !== 32'h99)
            begin errors++; $display("FAIL flush_result: got %0d/%b/%h want 0/00/99", a_busy_cnt, a_rd_busy, a_rd_data[63:32]); end
    endtask

    task automatic test_mid_reset();
        a_iss_en = 1'b1;
        for (int i = 10; i < 15; i++) begin
            a_iss_addr = 5'(i);
            step();
        end
        a_iss_en = 1'b0; a_rd_addr = {5'd10, 5'd10};
        #1;
        checks++;
        if (a_busy_cnt !== 5'd5 || a_rd_busy !== 2'b11)
            begin errors++; $display("FAIL pre_reset: got %0d/%b want 5/11", a_busy_cnt, a_rd_busy); end
        a_rst = 1'b1; a_wr_en = 1'b1; a_wr_addr = 5'd10; a_wr_data = 32'h55;
        step();
        a_wr_en = 1'b0;
        #1;
        checks++;
        if (a_busy_cnt !== 5'd0 || a_rd_busy !== 2'b00 || a_rd_data !== 64'd0)
            begin errors++; $display("FAIL mid_reset: got %0d/%b/%h want 0/00/0", a_busy_cnt, a_rd_busy, a_rd_data); end
        a_rst = 1'b0;
        step();
        a_rd_addr = {5'd4, 5'd7};
        #1;
        checks++;
        if (a_rd_data !== 64'd0 || a_busy_cnt !== 5'd0)
            begin errors++; $display("FAIL mid_reset_data: got %h/%0d want 0/0", a_rd_data, a_busy_cnt); end
    endtask

    task automatic test_random_traffic();
        logic [63:0] md [16];
        bit          mb [16];
        int          pc;
        logic [3:0]  ra;
        logic [63:0] ed;
        bit          eb, er;
        for (int i = 0; i < 16; i++) begin md[i] = '0; mb[i] = 1'b0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            c_iss_en   = 1'($urandom_range(0, 1));
            c_iss_addr = 4'($urandom_range(0, 15));
            c_wr_en    = 1'($urandom_range(0, 1));
            c_wr_addr  = 4'($urandom_range(0, 15));
            c_wr_data  = {$urandom, $urandom};
            c_flush    = ($urandom_range(0, 19) == 0);
            c_rd_addr[3:0] = 4'($urandom_range(0, 15));
            c_rd_addr[7:4] = 4'($urandom_range(0, 15));
            c_rd_addr[11:8] = ($urandom_range(0, 1) == 1) ? c_wr_addr : 4'($urandom_range(0, 15));
            #1;
            for (int p = 0; p < 3; p++) begin
                ra = c_rd_addr[p*4 +: 4];
                if (ra == 4'd0) begin ed = '0; eb = 1'b0; end
                else if (c_wr_en && c_wr_addr == ra) begin ed = c_wr_data; eb = 1'b0; end
                else begin ed = md[ra]; eb = mb[ra]; end
                checks++;
                if (c_rd_data[p*64 +: 64] !== ed || c_rd_busy[p] !== eb)
                    begin errors++; $display("FAIL rand_read c%0d p%0d x%0d: got %h/%b want %h/%b", cyc, p, ra, c_rd_data[p*64 +: 64], c_rd_busy[p], ed, eb); end
            end
            er = !c_flush && (c_iss_addr == 4'd0 || !mb[c_iss_addr] ||
                              (c_wr_en && c_wr_addr == c_iss_addr));
            checks++;
            if (c_iss_ready !== er)
                begin errors++; $display("FAIL rand_ready c%0d: got %b want %b", cyc, c_iss_ready, er); end
            step();
            if (c_wr_en && c_wr_addr != 4'd0) begin md[c_wr_addr] = c_wr_data; mb[c_wr_addr] = 1'b0; end
            if (c_iss_en && er && c_iss_addr != 4'd0) mb[c_iss_addr] = 1'b1;
            if (c_flush) for (int i = 0; i < 16; i++) mb[i] = 1'b0;
            pc = 0;
            for (int i = 0; i < 16; i++) pc += int'(mb[i]);
            checks++;
            if (c_busy_cnt !== 4'(pc))
                begin errors++; $display("FAIL rand_cnt c%0d: got %0d want %0d", cyc, c_busy_cnt, pc); end
        end
        c_iss_en = 1'b0; c_wr_en = 1'b0; c_flush = 1'b0;
    endtask

    initial begin
        a_rst = 1'b0; a_wr_en = 1'b0; a_iss_en = 1'b0; a_flush = 1'b0;
        a_rd_addr = '0; a_wr_addr = '0; a_iss_addr = '0; a_wr_data = '0;
        b_rst = 1'b0; b_wr_en = 1'b0; b_iss_en = 1'b0; b_flush = 1'b0;
        b_rd_addr = '0; b_wr_addr = '0; b_iss_addr = '0; b_wr_data = '0;
        c_rst = 1'b0; c_wr_en = 1'b0; c_iss_en = 1'b0; c_flush = 1'b0;
        c_rd_addr = '0; c_wr_addr = '0; c_iss_addr = '0; c_wr_data = '0;
        test_reset();
        test_issue_wb();
        test_bypass();
        test_fill_flush();
        test_mid_reset();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
